// File: rtl/approx_dot_accum.sv
// approx_dot_accum: streaming unsigned dot-product accumulator fed by the
// 16-bit products of the 8x8 approximate multiplier.
//
// Ports:
//   clk, rst_n (async, active-low), clr (synchronous abort)
//   prod_valid / prod_ready / prod[15:0] / prod_last : product beat input
//   out_valid / out_ready / out_sum / out_count / out_sat : group result
//
// Build option: define APPROX_DOT_SAT_EN to get a saturating accumulator
// (clamp to 2^ACC_W-1 and report out_sat). Undefined: wrap modulo 2^ACC_W.
module approx_dot_accum #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [15:0]      prod,
    input  logic             prod_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [LEN_W-1:0] out_count,
    output logic             out_sat
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] CNT_MAX = {LEN_W{1'b1}};

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [LEN_W-1:0] out_count_q, out_count_d;

    logic             take;
    logic             terminal;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] acc_next;
    logic [LEN_W-1:0] cnt_next;

`ifdef APPROX_DOT_SAT_EN
    logic             sat_q, sat_d;
    logic             out_sat_q, out_sat_d;
    logic             sat_next;
    logic [ACC_W:0]   wide_sum;
`endif

    assign prod_ready = (state_q != S_HOLD) | out_ready;
    assign take       = prod_valid & prod_ready;
    assign prod_ext   = {{(ACC_W-16){1'b0}}, prod};

    // acc/cnt/sat are zero in IDLE and HOLD (cleared when a group
    // closes), so a beat accepted there naturally gets first-beat
    // semantics without an explicit mux.
    assign cnt_next = cnt_q + 1'b1;
    assign terminal = prod_last | (cnt_next == CNT_MAX);

`ifdef APPROX_DOT_SAT_EN
    assign wide_sum = {1'b0, acc_q} + {1'b0, prod_ext};
    // Once saturated, stay clamped for the rest of the group.
    assign sat_next = sat_q | wide_sum[ACC_W];
    assign acc_next = sat_next ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
`else
    assign acc_next = acc_q + prod_ext;
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
`ifdef APPROX_DOT_SAT_EN
        sat_d       = sat_q;
        out_sat_d   = out_sat_q;
`endif
        if (clr) begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
`ifdef APPROX_DOT_SAT_EN
            sat_d   = 1'b0;
`endif
        end else if (take) begin
            if (terminal) begin
                state_d     = S_HOLD;
                out_sum_d   = acc_next;
                out_count_d = cnt_next;
                acc_d       = '0;
                cnt_d       = '0;
`ifdef APPROX_DOT_SAT_EN
                out_sat_d   = sat_next;
                sat_d       = 1'b0;
`endif
            end else begin
                state_d = S_ACCUM;
                acc_d   = acc_next;
                cnt_d   = cnt_next;
`ifdef APPROX_DOT_SAT_EN
                sat_d   = sat_next;
`endif
            end
        end else if (state_q == S_HOLD && out_ready) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_sum_q   <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
        end
    end

`ifdef APPROX_DOT_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q     <= 1'b0;
            out_sat_q <= 1'b0;
        end else begin
            sat_q     <= sat_d;
            out_sat_q <= out_sat_d;
        end
    end

    assign out_sat = out_sat_q;
`else
    assign out_sat = 1'b0;
`endif

    assign out_valid = (state_q == S_HOLD);
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_approx_dot_accum.sv
// tb_approx_dot_accum: directed self-checking bench for approx_dot_accum.
// Three instances (default, ACC_W=17, LEN_W=2) share one stimulus stream.
module tb_approx_dot_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        prod_valid;
    logic [15:0] prod;
    logic        prod_last;
    logic        out_ready;

    logic        rdy0, val0, sat0;
    logic [23:0] sum0;
    logic [7:0]  cnt0;

    logic        rdy17, val17, sat17;
    logic [16:0] sum17;
    logic [7:0]  cnt17;

    logic        rdy2, val2, sat2;
    logic [23:0] sum2;
    logic [1:0]  cnt2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    approx_dot_accum u_d0 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .prod_valid(prod_valid), .prod_ready(rdy0),
        .prod(prod), .prod_last(prod_last),
        .out_valid(val0), .out_ready(out_ready),
        .out_sum(sum0), .out_count(cnt0), .out_sat(sat0)
    );

    approx_dot_accum #(.ACC_W(17), .LEN_W(8)) u_d17 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .prod_valid(prod_valid), .prod_ready(rdy17),
        .prod(prod), .prod_last(prod_last),
        .out_valid(val17), .out_ready(out_ready),
        .out_sum(sum17), .out_count(cnt17), .out_sat(sat17)
    );

    approx_dot_accum #(.ACC_W(24), .LEN_W(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .prod_valid(prod_valid), .prod_ready(rdy2),
        .prod(prod), .prod_last(prod_last),
        .out_valid(val2), .out_ready(out_ready),
        .out_sum(sum2), .out_count(cnt2), .out_sat(sat2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] v, input logic l);
        prod_valid = 1'b1;
        prod       = v;
        prod_last  = l;
        tick();
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; prod_valid = 1'b0;
        prod = '0; prod_last = 1'b0; out_ready = 1'b0;
        tick();
        checks++;
        if (val0 !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b exp=0", val0);
        end
        checks++;
        if (sum0 !== 24'd0 || cnt0 !== 8'd0 || sat0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_out got=%0d/%0d/%b exp=0/0/0", sum0, cnt0, sat0);
        end
        checks++;
        if (rdy0 !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b exp=1", rdy0);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (rdy0 !== 1'b1 || val0 !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got=rdy%b val%b exp=rdy1 val0", rdy0, val0);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        beat(16'd100, 1'b0);
        beat(16'd200, 1'b0);
        checks++;
        if (val0 !== 1'b0) begin
            failures++; $display("FAIL basic_early got=%b exp=0", val0);
        end
        beat(16'd300, 1'b1);
        checks++;
        if (val0 !== 1'b1 || sum0 !== 24'd600 || cnt0 !== 8'd3 || sat0 !== 1'b0) begin
            failures++;
            $display("FAIL basic got=%b/%0d/%0d/%b exp=1/600/3/0", val0, sum0, cnt0, sat0);
        end
    endtask

    task automatic test_back_pressure();
        out_ready  = 1'b0;
        prod_valid = 1'b1;
        prod       = 16'd55;
        prod_last  = 1'b1;
        #1;
        checks++;
        if (rdy0 !== 1'b0) begin
            failures++; $display("FAIL bp_ready got=%b exp=0", rdy0);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (rdy0 !== 1'b0 || val0 !== 1'b1 || sum0 !== 24'd600 || cnt0 !== 8'd3) begin
                failures++;
                $display("FAIL bp_hold%0d got=r%b v%b %0d/%0d exp=r0 v1 600/3",
                         i, rdy0, val0, sum0, cnt0);
            end
        end
        out_ready = 1'b1;
        prod      = 16'd7;
        #1;
        checks++;
        if (rdy0 !== 1'b1) begin
            failures++; $display("FAIL bp_release_ready got=%b exp=1", rdy0);
        end
        tick();
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        checks++;
        if (val0 !== 1'b1 || sum0 !== 24'd7 || cnt0 !== 8'd1) begin
            failures++;
            $display("FAIL back_to_back got=%b/%0d/%0d exp=1/7/1", val0, sum0, cnt0);
        end
        tick();
        checks++;
        if (val0 !== 1'b0) begin
            failures++; $display("FAIL retire got=%b exp=0", val0);
        end
    endtask

    task automatic test_saturation();
        do_clr();
        beat(16'd65025, 1'b0);
        beat(16'd65025, 1'b0);
        beat(16'd65025, 1'b1);
`ifdef APPROX_DOT_SAT_EN
        checks++;
        if (val17 !== 1'b1 || sum17 !== 17'd131071 || sat17 !== 1'b1) begin
            failures++;
            $display("FAIL sat17 got=%b/%0d/%b exp=1/131071/1", val17, sum17, sat17);
        end
`else
        checks++;
        if (val17 !== 1'b1 || sum17 !== 17'd64003 || sat17 !== 1'b0) begin
            failures++;
            $display("FAIL wrap17 got=%b/%0d/%b exp=1/64003/0", val17, sum17, sat17);
        end
`endif
        checks++;
        if (sum0 !== 24'd195075 || cnt0 !== 8'd3 || sat0 !== 1'b0) begin
            failures++;
            $display("FAIL sat_wide got=%0d/%0d/%b exp=195075/3/0", sum0, cnt0, sat0);
        end
        tick();
    endtask

    task automatic test_forced_close();
        do_clr();
        beat(16'd1, 1'b0);
        beat(16'd1, 1'b0);
        beat(16'd1, 1'b0);
        checks++;
        if (val2 !== 1'b1 || sum2 !== 24'd3 || cnt2 !== 2'd3) begin
            failures++;
            $display("FAIL force1 got=%b/%0d/%0d exp=1/3/3", val2, sum2, cnt2);
        end
        beat(16'd1, 1'b0);
        checks++;
        if (val2 !== 1'b0) begin
            failures++; $display("FAIL force_mid got=%b exp=0", val2);
        end
        beat(16'd1, 1'b1);
        checks++;
        if (val2 !== 1'b1 || sum2 !== 24'd2 || cnt2 !== 2'd2) begin
            failures++;
            $display("FAIL force2 got=%b/%0d/%0d exp=1/2/2", val2, sum2, cnt2);
        end
        checks++;
        if (val0 !== 1'b1 || sum0 !== 24'd5 || cnt0 !== 8'd5) begin
            failures++;
            $display("FAIL force_wide got=%b/%0d/%0d exp=1/5/5", val0, sum0, cnt0);
        end
        tick();
    endtask

    task automatic test_abort();
        do_clr();
        beat(16'd10, 1'b0);
        beat(16'd20, 1'b0);
        clr = 1'b1;
        beat(16'd99, 1'b1);
        clr = 1'b0;
        checks++;
        if (val0 !== 1'b0) begin
            failures++; $display("FAIL abort_clr got=%b exp=0", val0);
        end
        tick();
        checks++;
        if (val0 !== 1'b0) begin
            failures++; $display("FAIL abort_idle got=%b exp=0", val0);
        end
        beat(16'd5, 1'b1);
        checks++;
        if (val0 !== 1'b1 || sum0 !== 24'd5 || cnt0 !== 8'd1) begin
            failures++;
            $display("FAIL abort_next got=%b/%0d/%0d exp=1/5/1", val0, sum0, cnt0);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        beat(16'd10, 1'b0);
        beat(16'd20, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (val0 !== 1'b0 || sum0 !== 24'd0 || rdy0 !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid got=v%b %0d r%b exp=v0 0 r1", val0, sum0, rdy0);
        end
        tick();
        tick();
        checks++;
        if (val0 !== 1'b0 || sum0 !== 24'd0 || rdy0 !== 1'b1) begin
            failures++;
            $display("FAIL rst_hold got=v%b %0d r%b exp=v0 0 r1", val0, sum0, rdy0);
        end
        rst_n = 1'b1;
        tick();
        beat(16'd4, 1'b1);
        checks++;
        if (val0 !== 1'b1 || sum0 !== 24'd4 || cnt0 !== 8'd1) begin
            failures++;
            $display("FAIL rst_after got=%b/%0d/%0d exp=1/4/1", val0, sum0, cnt0);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_pressure();
        test_saturation();
        test_forced_close();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/approx_dot_accum.md
# approx_dot_accum

- Streaming accumulator directly downstream of the 8x8 approximate multiplier (16-bit unsigned `prod8` output).
- Consumes one product per cycle over a valid/ready handshake and sums the products of a group delimited by a `last` flag.
- Presents each group's dot-product sum on a registered, back-pressurable output.
- Used to build approximate MAC / dot-product evaluation on the FPGA test fabric.

## Interface

Parameters:
- `ACC_W`, 24, accumulator and output sum width; legal range 17..32.
- `LEN_W`, 8, element-counter width; maximum group length is 2^LEN_W-1.

Ports:
- Clocking and reset: one clock `clk`; reset `rst_n`, asynchronous, active-low.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `clr`  in  1  synchronous abort; discards the group in progress.
- `prod_valid`  in  1  product beat valid.
- `prod_ready`  out  1  block can accept a beat.
- `prod`  in  16  unsigned product from the multiplier.
- `prod_last`  in  1  beat is the final element of its group.
- `out_valid`  out  1  group result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  ACC_W  group sum.
- `out_count`  out  LEN_W  number of beats in the group.
- `out_sat`  out  1  group sum saturated (see Configuration).

## Operation

- A beat is accepted when `prod_valid & prod_ready` is high at the clock edge.
- The sum is unsigned: `prod` is zero-extended to ACC_W.
- States:
  - IDLE: acc=0, cnt=0.
  - ACCUM: group open, acc and cnt hold partial results.
  - HOLD: result registered, `out_valid`=1.
- `prod_ready` = (state != HOLD) | `out_ready`. It is combinational from registered state and `out_ready`.
- IDLE, accepted beat:
  - acc=prod, cnt=1, sat=0.
  - If the beat is terminal, go to HOLD. Otherwise go to ACCUM.
- ACCUM, accepted beat:
  - acc=acc+prod, cnt=cnt+1, sat is sticky.
  - If the beat is terminal, go to HOLD.
- A beat is terminal when `prod_last`=1, or when the new cnt equals 2^LEN_W-1. In the second case the group is forcibly closed and the next beat starts a new group.
- HOLD:
  - `out_sum`/`out_count`/`out_sat` are stable while `out_valid`=1 and `out_ready`=0.
  - On `out_ready`=1 with no accepted beat, go to IDLE.
  - On `out_ready`=1 with an accepted beat (simultaneous event), the result retires and the beat opens a new group with IDLE-beat semantics. Throughput is 1 beat/cycle with no bubble.
- `clr`=1:
  - Next state is IDLE; acc, cnt and sat are cleared.
  - Any pending HOLD result is dropped.
  - A beat presented in the same cycle is ignored.
  - `clr` has priority over every other event.
- Reset mid-operation discards everything immediately; no partial result is emitted.

## Timing

- Reset values:
  - state=IDLE, `out_valid`=0, `out_sum`=0, `out_count`=0, `out_sat`=0.
  - `prod_ready`=1, both during and after reset.
- Latency: `out_valid` rises on the edge that accepts the terminal beat. The result is visible 1 cycle after that beat is presented.
- Output registers load only on the terminal-beat edge.
- No combinational path from `prod_valid`/`prod` to any output. The only combinational path is `out_ready` -> `prod_ready`.

## Configuration

- `APPROX_DOT_SAT_EN` defined:
  - The accumulator adds with an ACC_W+1-bit intermediate. On carry-out, acc clamps to 2^ACC_W-1 and sat is set.
  - sat remains set and acc remains clamped for the rest of the group. `out_sat` reports it.
- Not defined:
  - The sum wraps modulo 2^ACC_W.
  - `out_sat` is tied to 0 and the carry logic is not synthesised.

## Test plan

- Basic group (defaults): beats 100, 200, 300, `last` on the third, `out_ready`=1 -> one cycle after the third beat: `out_valid`=1, `out_sum`=600, `out_count`=3, `out_sat`=0.
- Back-pressure: hold `out_ready`=0 for 5 cycles after result 600 -> `prod_ready`=0 and outputs stable for all 5 cycles. Then `out_ready`=1 together with beat 7 (last) -> 600 retires, and the next cycle shows `out_sum`=7, `out_count`=1 with no idle cycle.
- Saturation (ACC_W=17): beats 65025 x3, last on the third -> with macro: `out_sum`=131071, `out_sat`=1. Without macro: `out_sum`=64003, `out_sat`=0.
- Forced close (LEN_W=2): five beats of value 1, `last` only on the fifth -> first result `out_sum`=3 / `out_count`=3, second result 2 / 2.
- Abort: beats 10, 20 then `clr`=1 with `prod_valid`=1, prod=99 -> no output. A following beat of 5 (last) yields 5 / 1.
- Reset mid-operation: beats 10, 20 accepted, then `rst_n` low for 2 cycles -> `out_valid`=0, `out_sum`=0, `prod_ready`=1 during reset. After release, beat 4 (last) yields 4 / 1.
